// File: rtl/axi_pkg.sv
// Shared AXI master read-engine command/status types and constants.
package axi_pkg;

    localparam int         AXI_ADDR_W    = 32;
    localparam int         AXI_LEN_W     = 16;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
    } AxiMasterRdCtrl_t;

    typedef struct packed {
        logic [1:0] resp;
    } AxiMasterRdStatus_t;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_ISSUE = 2'd1,
        FS_DRAIN = 2'd2
    } frame_sched_fsm_t;

endpackage

// File: rtl/axi_frame_rd_sched.sv
// Frame read scheduler: one line-sized read command per line, paced by consumer line credits.
// Command valid registers one cycle after frame_start/credit; held until handshake; status never stalled.
module axi_frame_rd_sched
    import axi_pkg::*;
#(
    parameter int AXI_AWIDTH = 32,
    parameter int LEN_W      = 16,
    parameter int LINES_W    = 12,
    parameter int MAX_OUT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_enable,
    input  logic [AXI_AWIDTH-1:0]    cfg_base_addr,
    input  logic [LEN_W-1:0]         cfg_stride,
    input  logic [LEN_W-1:0]         cfg_line_bytes,
    input  logic [LINES_W-1:0]       cfg_lines,
    input  logic                     frame_start,
    input  logic                     line_credit,
    input  logic                     err_clr,
    output logic                     m_axis_cmd_tvalid,
    input  logic                     m_axis_cmd_tready,
    output AxiMasterRdCtrl_t         m_axis_cmd_tdata,
    input  logic                     s_axis_status_tvalid,
    output logic                     s_axis_status_tready,
    input  AxiMasterRdStatus_t       s_axis_status_tdata,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err_resp,
    output logic                     err_overrun
);

    localparam int                CRED_W   = $clog2(MAX_OUT + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUT);

    frame_sched_fsm_t      state_q, state_d;
    logic [AXI_AWIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      stride_q, stride_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LINES_W-1:0]    lines_left_q, lines_left_d;
    logic [LINES_W-1:0]    outst_q, outst_d;
    logic [CRED_W-1:0]     credit_q, credit_d;
    logic                  tvalid_q, tvalid_d;
    logic                  aborted_q, aborted_d;
    logic                  done_q, done_d;
    logic                  err_resp_q, err_resp_d;
    logic                  err_ovr_q, err_ovr_d;
    logic                  sts_rdy_q;

    logic cmd_hs, sts_hs, start_ok, empty_frame, last_hs, drain_done;

    assign cmd_hs      = tvalid_q & m_axis_cmd_tready;
    assign sts_hs      = s_axis_status_tvalid & sts_rdy_q;
    assign start_ok    = (state_q == FS_IDLE) & frame_start & cfg_enable;
    assign empty_frame = (cfg_lines == '0) | (cfg_line_bytes == '0);
    assign last_hs     = cmd_hs & (lines_left_q == LINES_W'(1));
    // A command still waiting for tready keeps the frame in DRAIN even with nothing outstanding.
    assign drain_done  = ~tvalid_d & (outst_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FS_IDLE;
            addr_q       <= '0;
            stride_q     <= '0;
            len_q        <= '0;
            lines_left_q <= '0;
            outst_q      <= '0;
            credit_q     <= '0;
            tvalid_q     <= 1'b0;
            aborted_q    <= 1'b0;
            done_q       <= 1'b0;
            err_resp_q   <= 1'b0;
            err_ovr_q    <= 1'b0;
            sts_rdy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            stride_q     <= stride_d;
            len_q        <= len_d;
            lines_left_q <= lines_left_d;
            outst_q      <= outst_d;
            credit_q     <= credit_d;
            tvalid_q     <= tvalid_d;
            aborted_q    <= aborted_d;
            done_q       <= done_d;
            err_resp_q   <= err_resp_d;
            err_ovr_q    <= err_ovr_d;
            sts_rdy_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        aborted_d = aborted_q;
        case (state_q)
            FS_IDLE: begin
                if (start_ok) begin
                    state_d   = empty_frame ? FS_DRAIN : FS_ISSUE;
                    aborted_d = 1'b0;
                end
            end
            FS_ISSUE: begin
                if (last_hs) begin
                    state_d = FS_DRAIN;
                end else if (!cfg_enable) begin
                    state_d   = FS_DRAIN;
                    aborted_d = 1'b1;
                end
            end
            FS_DRAIN: begin
                if (drain_done) state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        stride_d     = stride_q;
        len_d        = len_q;
        lines_left_d = lines_left_q;
        credit_d     = credit_q;
        outst_d      = outst_q;
        tvalid_d     = 1'b0;
        done_d       = 1'b0;

        if (start_ok) begin
            addr_d       = cfg_base_addr;
            stride_d     = cfg_stride;
            len_d        = cfg_line_bytes;
            lines_left_d = cfg_lines;
            credit_d     = CRED_MAX;
        end else begin
            if (cmd_hs) begin
                addr_d       = addr_q + AXI_AWIDTH'(stride_q);
                lines_left_d = lines_left_q - LINES_W'(1);
            end
            if (line_credit && !cmd_hs && credit_q != CRED_MAX) begin
                credit_d = credit_q + CRED_W'(1);
            end else if (cmd_hs && !line_credit) begin
                credit_d = credit_q - CRED_W'(1);
            end
        end

        if (cmd_hs && !sts_hs) begin
            outst_d = outst_q + LINES_W'(1);
        end else if (sts_hs && !cmd_hs && outst_q != '0) begin
            outst_d = outst_q - LINES_W'(1);
        end

        case (state_q)
            FS_IDLE:  tvalid_d = start_ok & ~empty_frame;
            FS_ISSUE: tvalid_d = ~last_hs & ((tvalid_q & ~cmd_hs) |
                                 (cfg_enable & (credit_d != '0) & (lines_left_d != '0)));
            FS_DRAIN: tvalid_d = tvalid_q & ~cmd_hs;
            default:  tvalid_d = 1'b0;
        endcase

        done_d     = (state_q == FS_DRAIN) & drain_done & ~aborted_q;
        err_resp_d = (sts_hs & ((s_axis_status_tdata.resp != AXI_RESP_OKAY) | (outst_q == '0)))
                   | (err_resp_q & ~err_clr);
        err_ovr_d  = (frame_start & (state_q != FS_IDLE)) | (err_ovr_q & ~err_clr);
    end

    assign m_axis_cmd_tvalid     = tvalid_q;
    assign m_axis_cmd_tdata.addr = addr_q;
    assign m_axis_cmd_tdata.len  = len_q;
    assign s_axis_status_tready  = sts_rdy_q;
    assign busy                  = (state_q != FS_IDLE);
    assign frame_done            = done_q;
    assign err_resp              = err_resp_q;
    assign err_overrun           = err_ovr_q;

endmodule

// File: tb/tb_axi_frame_rd_sched.sv
// Bench for axi_frame_rd_sched: directed frames against an expected-command queue and credit model.
module tb_axi_frame_rd_sched;
    import axi_pkg::*;

    localparam int MAXO = 4;

    logic               clk = 1'b0;
    logic               rst, cfg_enable, frame_start, line_credit, err_clr;
    logic [31:0]        cfg_base_addr;
    logic [15:0]        cfg_stride, cfg_line_bytes;
    logic [11:0]        cfg_lines;
    logic               tvalid, tready, s_tvalid, s_tready;
    AxiMasterRdCtrl_t   tdata;
    AxiMasterRdStatus_t sdata;
    logic               busy, frame_done, err_resp, err_overrun;

    axi_frame_rd_sched #(
        .AXI_AWIDTH(32), .LEN_W(16), .LINES_W(12), .MAX_OUT(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride),
        .cfg_line_bytes(cfg_line_bytes), .cfg_lines(cfg_lines),
        .frame_start(frame_start), .line_credit(line_credit), .err_clr(err_clr),
        .m_axis_cmd_tvalid(tvalid), .m_axis_cmd_tready(tready), .m_axis_cmd_tdata(tdata),
        .s_axis_status_tvalid(s_tvalid), .s_axis_status_tready(s_tready),
        .s_axis_status_tdata(sdata),
        .busy(busy), .frame_done(frame_done), .err_resp(err_resp), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    AxiMasterRdCtrl_t exp_q[$];
    int               mcredit = 0;
    logic             prev_pend = 1'b0;
    AxiMasterRdCtrl_t prev_dat;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected commands of a frame: line i starts at base + i*stride, 32-bit wrap.
    task automatic push_frame(input logic [31:0] base, input logic [15:0] stride,
                              input logic [15:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            AxiMasterRdCtrl_t c;
            c.addr = base + 32'(i) * {16'h0, stride};
            c.len  = bytes;
            exp_q.push_back(c);
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                               input logic [15:0] bytes, input logic [11:0] lines);
        cfg_base_addr  = base;
        cfg_stride     = stride;
        cfg_line_bytes = bytes;
        cfg_lines      = lines;
        frame_start    = 1'b1;
        step();
        frame_start    = 1'b0;
    endtask

    task automatic send_status(input logic [1:0] resp);
        s_tvalid   = 1'b1;
        sdata.resp = resp;
        step();
        s_tvalid   = 1'b0;
        sdata.resp = 2'b00;
    endtask

    // Per-cycle compare: command contents/order, hold-while-stalled, and issue only with credit.
    always @(negedge clk) begin
        if (rst) begin
            prev_pend = 1'b0;
            mcredit   = 0;
        end else begin
            if (prev_pend) begin
                chk("hold_vld", tvalid, 1);
                chk("hold_dat", tdata, prev_dat);
            end
            if (tvalid && tready) begin
                chk("issue_credit", mcredit > 0, 1);
                chk("cmd_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("cmd_dat", tdata, exp_q.pop_front());
            end
            if (frame_start && cfg_enable && !busy) begin
                mcredit = MAXO;
            end else begin
                mcredit = mcredit - int'(tvalid && tready) + int'(line_credit);
                if (mcredit > MAXO) mcredit = MAXO;
            end
            prev_pend = tvalid && !tready;
            prev_dat  = tdata;
        end
    end

    initial begin
        int cnt;
        rst = 1'b1; cfg_enable = 1'b1; frame_start = 1'b0; line_credit = 1'b0; err_clr = 1'b0;
        cfg_base_addr = '0; cfg_stride = '0; cfg_line_bytes = '0; cfg_lines = '0;
        tready = 1'b1; s_tvalid = 1'b0; sdata.resp = 2'b00;
        repeat (3) step();
        chk("rst_vld", tvalid, 0);
        chk("rst_dat", tdata, 0);
        chk("rst_sts_rdy", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err_resp", err_resp, 0);
        chk("rst_err_ovr", err_overrun, 0);
        rst = 1'b0;
        step();
        chk("sts_rdy", s_tready, 1);

        // Normal frame, back-to-back issue
        push_frame(32'h1000_0000, 16'h0800, 16'd1440, 3);
        start_frame(32'h1000_0000, 16'h0800, 16'd1440, 12'd3);
        chk("n_vld0", tvalid, 1);
        chk("n_addr0", tdata.addr, 32'h1000_0000);
        chk("n_len", tdata.len, 1440);
        step(); chk("n_addr1", tdata.addr, 32'h1000_0800);
        step(); chk("n_addr2", tdata.addr, 32'h1000_1000);
        step(); chk("n_vld_end", tvalid, 0); chk("n_busy", busy, 1);
        send_status(2'b00); chk("n_done_early", frame_done, 0);
        send_status(2'b00);
        send_status(2'b00);
        chk("n_done", frame_done, 1); chk("n_busy_end", busy, 0);
        step(); chk("n_done_pulse", frame_done, 0);

        // Credit pacing
        push_frame(32'h2000_0000, 16'h0100, 16'd64, 6);
        start_frame(32'h2000_0000, 16'h0100, 16'd64, 12'd6);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (tvalid) cnt++;
            step();
        end
        chk("pace_first", cnt, 4);
        line_credit = 1'b1; step(); line_credit = 1'b0;
        chk("pace_c1_vld", tvalid, 1); chk("pace_c1_addr", tdata.addr, 32'h2000_0400);
        step(); chk("pace_c1_one", tvalid, 0);
        line_credit = 1'b1; step(); line_credit = 1'b0;
        chk("pace_c2_vld", tvalid, 1); chk("pace_c2_addr", tdata.addr, 32'h2000_0500);
        step(); chk("pace_c2_one", tvalid, 0);
        for (int i = 0; i < 6; i++) send_status(2'b00);
        chk("pace_done", frame_done, 1);

        // Backpressure, then credit coinciding with a handshake
        tready = 1'b0;
        push_frame(32'h3000_0000, 16'h0040, 16'd16, 6);
        start_frame(32'h3000_0000, 16'h0040, 16'd16, 12'd6);
        repeat (5) step();
        chk("bp_vld", tvalid, 1); chk("bp_addr", tdata.addr, 32'h3000_0000);
        tready = 1'b1; line_credit = 1'b1; step(); line_credit = 1'b0;
        cnt = 1;
        for (int i = 0; i < 8; i++) begin
            if (tvalid) cnt++;
            step();
        end
        chk("bp_sim_credit", cnt, 5);
        line_credit = 1'b1; step(); line_credit = 1'b0;
        chk("bp_last_addr", tdata.addr, 32'h3000_0140);
        step();
        for (int i = 0; i < 6; i++) send_status(2'b00);
        chk("bp_done", frame_done, 1);

        // Errors: overrun, bad resp, clear, set-wins-over-clear
        push_frame(32'h4000_0000, 16'h1000, 16'd256, 2);
        start_frame(32'h4000_0000, 16'h1000, 16'd256, 12'd2);
        step(); step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("ovr_set", err_overrun, 1); chk("ovr_busy", busy, 1);
        send_status(2'b10); chk("resp_set", err_resp, 1);
        send_status(2'b00); chk("err_frame_done", frame_done, 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("clr_resp", err_resp, 0); chk("clr_ovr", err_overrun, 0);
        err_clr = 1'b1; s_tvalid = 1'b1; step(); err_clr = 1'b0; s_tvalid = 1'b0;
        chk("set_wins", err_resp, 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("clr_again", err_resp, 0);

        // Empty frame, then address wrap
        start_frame(32'h6000_0000, 16'h0010, 16'd16, 12'd0);
        chk("empty_busy", busy, 1); chk("empty_vld", tvalid, 0);
        step(); chk("empty_done", frame_done, 1); chk("empty_idle", busy, 0);
        push_frame(32'hFFFF_F800, 16'h0800, 16'd8, 2);
        start_frame(32'hFFFF_F800, 16'h0800, 16'd8, 12'd2);
        chk("wrap_a0", tdata.addr, 32'hFFFF_F800);
        step(); chk("wrap_a1", tdata.addr, 32'h0000_0000);
        step();
        send_status(2'b00); send_status(2'b00);
        chk("wrap_done", frame_done, 1);

        // Abort with a command pending
        tready = 1'b0;
        push_frame(32'h5000_0000, 16'h0200, 16'd32, 1);
        start_frame(32'h5000_0000, 16'h0200, 16'd32, 12'd4);
        chk("ab_vld", tvalid, 1);
        cfg_enable = 1'b0; step();
        chk("ab_hold", tvalid, 1); chk("ab_busy", busy, 1);
        step(); tready = 1'b1; step();
        chk("ab_hs_vld", tvalid, 0);
        repeat (3) step();
        chk("ab_no_more", tvalid, 0); chk("ab_wait_sts", busy, 1);
        send_status(2'b00);
        chk("ab_idle", busy, 0); chk("ab_no_done", frame_done, 0);
        step(); chk("ab_no_done2", frame_done, 0);
        cfg_enable = 1'b1;

        // Reset mid-frame, then a late status
        tready = 1'b0;
        start_frame(32'h7000_0000, 16'h0020, 16'd8, 12'd3);
        chk("mr_vld", tvalid, 1);
        rst = 1'b1; step();
        chk("mr_vld0", tvalid, 0); chk("mr_busy0", busy, 0); chk("mr_dat0", tdata, 0);
        rst = 1'b0; step(); tready = 1'b1;
        send_status(2'b00); chk("mr_stray", err_resp, 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;

        // frame_start while disabled in IDLE is ignored
        cfg_enable = 1'b0;
        start_frame(32'h8000_0000, 16'h0020, 16'd8, 12'd3);
        chk("dis_busy", busy, 0); chk("dis_ovr", err_overrun, 0); chk("dis_vld", tvalid, 0);
        cfg_enable = 1'b1;
        step();
        chk("cmds_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
